// File: rtl/movz_const_encoder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | movz_const_encoder_if : request / instruction-beat handshake bus  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface movz_const_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_imm26;
  logic [2:0]  out_ctrl;
  logic [1:0]  out_op;
  logic        out_last;

  modport master (
    output in_valid, in_value, in_rd, out_ready,
    input  in_ready, out_valid, out_imm26, out_ctrl, out_op, out_last
  );

  modport slave (
    input  in_valid, in_value, in_rd, out_ready,
    output in_ready, out_valid, out_imm26, out_ctrl, out_op, out_last
  );
endinterface
`default_nettype wire

// File: rtl/movz_const_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | movz_const_encoder : 64-bit constant -> MOVZ/MOVK(/MOVN) beats    |
// | Optional MOVN selection under macro MOVZ_CONST_MOVN_EN. Rev 1.0   |
// +------------------------------------------------------------------+
module movz_const_encoder #(
  parameter bit DESCEND = 1'b0
) (
  input  wire logic           CLK,
  input  wire logic           Reset_L,
  movz_const_encoder_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [1:0] OP_MOVZ = 2'b00;
  localparam logic [1:0] OP_MOVK = 2'b10;
`ifdef MOVZ_CONST_MOVN_EN
  localparam logic [1:0] OP_MOVN = 2'b01;
`endif

  state_t      state_q, state_d;
  logic [63:0] value_q, value_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  mask_q, mask_d;
  logic        out_valid_q, out_valid_d;
  logic [25:0] out_imm26_q, out_imm26_d;
  logic [2:0]  out_ctrl_q, out_ctrl_d;
  logic [1:0]  out_op_q, out_op_d;
  logic        out_last_q, out_last_d;

  logic [3:0]  w_mask;
  logic [3:0]  w_first_sel;
  logic [1:0]  w_first_hw;
  logic [15:0] w_first_imm;
  logic [1:0]  w_first_op;
  logic [1:0]  w_next_hw;
  logic [3:0]  w_next_rem;
  logic [3:0]  w_first_rem;
`ifdef MOVZ_CONST_MOVN_EN
  logic [3:0]  w_nmask;
`endif

  // Empty mask yields the zero-constant halfword (hw0, or hw3 when descending).
  function automatic logic [1:0] pick_hw(input logic [3:0] m);
    logic [1:0] hw;
    hw = DESCEND ? 2'd3 : 2'd0;
    if (DESCEND) begin
      for (int i = 0; i < 4; i++) if (m[i]) hw = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--) if (m[i]) hw = 2'(i);
    end
    return hw;
  endfunction

  function automatic logic [15:0] hword(input logic [63:0] v, input logic [1:0] hw);
    logic [15:0] h;
    case (hw)
      2'd0:    h = v[15:0];
      2'd1:    h = v[31:16];
      2'd2:    h = v[47:32];
      default: h = v[63:48];
    endcase
    return h;
  endfunction

`ifdef MOVZ_CONST_MOVN_EN
  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    rd_d        = rd_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_imm26_d = out_imm26_q;
    out_ctrl_d  = out_ctrl_q;
    out_op_d    = out_op_q;
    out_last_d  = out_last_q;

    for (int i = 0; i < 4; i++) w_mask[i] = |bus.in_value[16*i +: 16];
    w_first_sel = w_mask;
    w_first_op  = OP_MOVZ;
    w_first_hw  = pick_hw(w_mask);
    w_first_imm = hword(bus.in_value, w_first_hw);
`ifdef MOVZ_CONST_MOVN_EN
    for (int i = 0; i < 4; i++) w_nmask[i] = ~&bus.in_value[16*i +: 16];
    if (popcount4(w_nmask) < popcount4(w_mask)) begin
      w_first_sel = w_nmask;
      w_first_op  = OP_MOVN;
      w_first_hw  = (w_nmask == 4'd0) ? 2'd0 : pick_hw(w_nmask);
      w_first_imm = ~hword(bus.in_value, w_first_hw);
    end
`endif
    w_first_rem = w_first_sel & ~(4'b0001 << w_first_hw);
    w_next_hw   = pick_hw(mask_q);
    w_next_rem  = mask_q & ~(4'b0001 << w_next_hw);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          value_d     = bus.in_value;
          rd_d        = bus.in_rd;
          mask_d      = w_first_rem;
          out_valid_d = 1'b1;
          out_imm26_d = {3'b000, w_first_hw, w_first_imm, bus.in_rd};
          out_ctrl_d  = {1'b1, w_first_hw};
          out_op_d    = w_first_op;
          out_last_d  = (w_first_rem == 4'd0);
          state_d     = EMIT;
        end
      end
      default: begin
        if (out_valid_q && bus.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            mask_d      = 4'd0;
            state_d     = IDLE;
          end else begin
            mask_d      = w_next_rem;
            out_imm26_d = {3'b000, w_next_hw, hword(value_q, w_next_hw), rd_q};
            out_ctrl_d  = {1'b1, w_next_hw};
            out_op_d    = OP_MOVK;
            out_last_d  = (w_next_rem == 4'd0);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= IDLE;
      value_q     <= '0;
      rd_q        <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_imm26_q <= '0;
      out_ctrl_q  <= '0;
      out_op_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      rd_q        <= rd_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_imm26_q <= out_imm26_d;
      out_ctrl_q  <= out_ctrl_d;
      out_op_q    <= out_op_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm26 = out_imm26_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_last  = out_last_q;

endmodule
`default_nettype wire
